// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared core widths, fetch FSM encoding and the fetch-entry layout
package rv_core_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer with flush and a registered head entry
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd, r_wr, w_rd_next;
    logic [AW:0]      r_count, w_left, w_next;
    logic             r_valid, w_pop, w_push;
    logic [WIDTH-1:0] r_dout;
    assign w_pop     = i_pop && r_count != '0;
    assign w_push    = i_push && (r_count != FULL || w_pop);
    assign w_left    = r_count - (AW+1)'(w_pop);
    assign w_next    = w_left + (AW+1)'(w_push);
    assign w_rd_next = r_rd + AW'(w_pop);
    assign o_count   = r_count;
    assign o_valid   = r_valid;
    assign o_dout    = r_dout;
    // The head register tracks the entry that will be at the read pointer after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1'b1);
            r_rd    <= w_rd_next;
            r_count <= w_next;
            r_valid <= w_next != '0;
            if (w_next != '0) r_dout <= (w_left == '0) ? i_din : r_mem[w_rd_next];
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, single-outstanding imem fetch FSM and decoder-facing buffer
module instruction_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            imem_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc, r_out_pc;
    logic [AW:0]     w_count;
    logic            w_credit, w_gnt, w_push, w_pop;
    fetch_entry_t    w_din, w_dout;
    // A word returning this cycle frees its outstanding slot but takes a FIFO slot, so the sum is unchanged.
    assign w_credit  = ({1'b0, w_count} + (AW+2)'(r_state != S_IDLE)) < (AW+2)'(FIFO_DEPTH);
    assign imem_req  = rst_n && !redirect_valid && w_credit &&
                       (r_state == S_IDLE || (r_state == S_WAIT && imem_rvalid));
    assign imem_addr = r_pc;
    assign w_gnt     = imem_req && imem_gnt;
    assign w_push    = r_state == S_WAIT && imem_rvalid && !redirect_valid;
    assign w_pop     = if_valid && if_ready;
    assign w_din     = '{pc: r_out_pc, instr: imem_err ? NOP_INSTR : imem_rdata, fault: imem_err};
    assign if_instr  = w_dout.instr;
    assign if_pc     = w_dout.pc;
    assign if_fault  = w_dout.fault;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_out_pc <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            r_state <= (r_state != S_IDLE && !imem_rvalid) ? S_DISCARD : S_IDLE;
        end else if (w_gnt) begin
            r_pc     <= r_pc + 32'd4;
            r_out_pc <= r_pc;
            r_state  <= S_WAIT;
        end else if (imem_rvalid && r_state != S_IDLE) begin
            r_state <= S_IDLE;
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_valid (if_valid),
        .o_dout  (w_dout)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized bus/decoder stimulus against a sequential-PC stream model
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid, if_ready = 1'b1, if_fault;
    logic [31:0] if_instr, if_pc;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int cnt; } pend_t;
    pend_t       pend_q[$];
    int          n_cmp = 0, n_err = 0, n_grant = 0, n_hs = 0;
    int          gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, gnt_block = 0;
    logic [31:0] err_addr = 32'h1, exp_fetch = '0, exp_pc = '0;
    logic [31:0] last_grant_addr = '0, last_hs_pc = '0, last_hs_instr = '0, s_addr = '0;
    logic        last_hs_fault = 1'b0, s_req = 1'b0, s_gnt = 1'b0, s_valid = 1'b0;
    logic        p_req_pend = 1'b0, p_hold = 1'b0, p_fault = 1'b0;
    logic [31:0] p_addr = '0, p_pc = '0, p_instr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic restart_model();
        exp_fetch  = 32'h0;
        exp_pc     = 32'h0;
        p_req_pend = 1'b0;
        p_hold     = 1'b0;
        pend_q.delete();
    endtask

    // One clock: sample and check at negedge, grant decision, then drive bus/decoder after posedge.
    task automatic step();
        logic  g;
        pend_t p;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
        if (p_req_pend && !redirect_valid) begin
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
                n_err++;
                $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, p_addr);
            end
        end
        if (p_hold) begin
            n_cmp++;
            if ({if_valid, if_pc, if_instr, if_fault} !== {1'b1, p_pc, p_instr, p_fault}) begin
                n_err++;
                $display("FAIL if_hold: valid=%0b pc=%h instr=%h fault=%0b, required 1 %h %h %0b",
                         if_valid, if_pc, if_instr, if_fault, p_pc, p_instr, p_fault);
            end
        end
        if (imem_req) begin
            n_cmp++;
            if ({redirect_valid, pend_q.size() != 0} !== 2'b00) begin
                n_err++;
                $display("FAIL req_legal: req raised with redirect=%0b outstanding=%0d, required none",
                         redirect_valid, pend_q.size());
            end
        end
        g = imem_req && gnt_block == 0 && int'($urandom_range(99)) < gnt_pct;
        if (imem_req && gnt_block > 0) gnt_block--;
        imem_gnt = g;
        s_gnt = g;
        if (g) begin
            n_cmp++;
            if (imem_addr !== exp_fetch) begin
                n_err++;
                $display("FAIL fetch_addr: got %h, required %h", imem_addr, exp_fetch);
            end
            p.addr = imem_addr;
            p.cnt  = int'($urandom_range(lat_max, lat_min));
            pend_q.push_back(p);
            exp_fetch += 32'd4;
            n_grant++;
            last_grant_addr = imem_addr;
        end
        if (if_valid && if_ready) begin
            n_cmp++;
            if ({if_pc, if_instr, if_fault} !== {exp_pc, (exp_pc == err_addr) ? NOP : mem_word(exp_pc), exp_pc == err_addr}) begin
                n_err++;
                $display("FAIL handshake: got pc=%h instr=%h fault=%0b, required pc=%h instr=%h fault=%0b",
                         if_pc, if_instr, if_fault, exp_pc, (exp_pc == err_addr) ? NOP : mem_word(exp_pc),
                         exp_pc == err_addr);
            end
            exp_pc += 32'd4;
            n_hs++;
            last_hs_pc = if_pc; last_hs_instr = if_instr; last_hs_fault = if_fault;
        end
        p_req_pend = imem_req && !g;
        p_addr = imem_addr;
        p_hold = if_valid && !if_ready && !redirect_valid;
        p_pc = if_pc; p_instr = if_instr; p_fault = if_fault;
        if (redirect_valid) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end
        @(posedge clk);
        #1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
        if (pend_q.size() != 0) begin
            p = pend_q[0];
            p.cnt--;
            if (p.cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(p.addr);
                imem_err    = p.addr == err_addr;
                void'(pend_q.pop_front());
            end else pend_q[0] = p;
        end
        if_ready = int'($urandom_range(99)) < rdy_pct;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_bus: req=%0b addr=%h, required 0 00000000", imem_req, imem_addr);
        end
        n_cmp++;
        if ({if_valid, if_instr, if_pc, if_fault} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_if: valid=%0b instr=%h pc=%h fault=%0b, required all zero",
                     if_valid, if_instr, if_pc, if_fault);
        end
        restart_model();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0] seen;
        int h0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen[i] = s_valid;
        end
        n_cmp++;
        if (seen !== 3'b100) begin
            n_err++;
            $display("FAIL first_valid: if_valid over 3 cycles (newest msb)=%b, required 100", seen);
        end
        n_cmp++;
        if ({n_hs, last_hs_pc, last_hs_instr} !== {32'd1, 32'h0, 32'h0050_0093}) begin
            n_err++;
            $display("FAIL first_word: hs=%0d pc=%h instr=%h, required 1 00000000 00500093", n_hs, last_hs_pc, last_hs_instr);
        end
        h0 = n_hs;
        repeat (20) step();
        n_cmp++;
        if (n_hs - h0 != 20) begin
            n_err++;
            $display("FAIL throughput: %0d words in 20 cycles, required 20", n_hs - h0);
        end
    endtask

    task automatic test_backpressure();
        int g0, h0, k;
        rdy_pct = 0;
        if_ready = 1'b0;
        g0 = n_grant;
        do_redirect(32'h0);
        repeat (10) step();
        n_cmp++;
        if (n_grant - g0 != 4) begin
            n_err++;
            $display("FAIL bp_grants: %0d requests accepted while stalled, required 4", n_grant - g0);
        end
        n_cmp++;
        if ({s_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL bp_state: req=%0b valid=%0b pc=%h, required 0 1 00000000", s_req, if_valid, if_pc);
        end
        rdy_pct = 100;
        if_ready = 1'b1;
        h0 = n_hs;
        k = 0;
        while (n_hs - h0 < 5 && k < 30) begin
            step();
            k++;
        end
        n_cmp++;
        if ({n_hs - h0, last_hs_pc} !== {32'd5, 32'h10}) begin
            n_err++;
            $display("FAIL bp_drain: %0d words last pc=%h, required 5 words ending at 00000010", n_hs - h0, last_hs_pc);
        end
    endtask

    task automatic test_redirect();
        int g0, h0, k;
        logic got;
        logic [31:0] fa;
        lat_min = 4; lat_max = 4;
        k = 0;
        while (pend_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if (pend_q.size() == 0) begin
            n_err++;
            $display("FAIL redir_setup: no outstanding request within 20 cycles, required one");
        end
        do_redirect(32'h0000_0102);
        g0 = n_grant; h0 = n_hs;
        step();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_flush: if_valid=%0b the cycle after redirect, required 0", s_valid);
        end
        got = 1'b0; fa = '0; k = 0;
        while (n_hs == h0 && k < 40) begin
            if (n_grant > g0 && !got) begin
                got = 1'b1;
                fa = last_grant_addr;
            end
            step();
            k++;
        end
        n_cmp++;
        if ({fa, last_hs_pc, n_hs > h0} !== {32'h100, 32'h100, 1'b1}) begin
            n_err++;
            $display("FAIL redir_target: first addr=%h first pc=%h, required 00000100 00000100", fa, last_hs_pc);
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_gnt_stall();
        int req_cycles, k;
        logic moved;
        logic [31:0] a0;
        gnt_pct = 100; lat_min = 5; lat_max = 5;
        gnt_block = 3;
        req_cycles = 0; moved = 1'b0; a0 = '0; k = 0;
        do begin
            step();
            if (s_req) begin
                if (req_cycles == 0) a0 = s_addr;
                else if (s_addr != a0) moved = 1'b1;
                req_cycles++;
            end
            k++;
        end while (!s_gnt && k < 30);
        n_cmp++;
        if ({req_cycles, moved} !== {32'd4, 1'b0}) begin
            n_err++;
            $display("FAIL gnt_stall: req high %0d cycles addr_moved=%0b, required 4 cycles addr_moved=0", req_cycles, moved);
        end
        gnt_pct = 60; lat_min = 1;
        repeat (40) step();
        gnt_pct = 100; lat_max = 1;
    endtask

    task automatic test_fault();
        int k;
        err_addr = 32'h8;
        lat_min = 1; lat_max = 3;
        do_redirect(32'h0);
        last_hs_pc = '1;
        k = 0;
        while (last_hs_pc != 32'h8 && k < 40) begin
            step();
            k++;
        end
        n_cmp++;
        if ({last_hs_pc, last_hs_instr, last_hs_fault} !== {32'h8, NOP, 1'b1}) begin
            n_err++;
            $display("FAIL fault_word: pc=%h instr=%h fault=%0b, required 00000008 00000013 1",
                     last_hs_pc, last_hs_instr, last_hs_fault);
        end
        err_addr = 32'h1;
        lat_max = 1;
    endtask

    task automatic test_wrap_and_async_reset();
        int g0, h0, k;
        logic [31:0] a [2];
        do_redirect(32'hFFFF_FFFC);
        g0 = n_grant; k = 0;
        a[0] = '0; a[1] = '0;
        while (n_grant - g0 < 2 && k < 20) begin
            step();
            if (s_gnt) a[n_grant - g0 - 1] = last_grant_addr;
            k++;
        end
        n_cmp++;
        if ({a[0], a[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
            n_err++;
            $display("FAIL pc_wrap: fetch addrs %h %h, required fffffffc 00000000", a[0], a[1]);
        end
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault} !== 67'h0) begin
            n_err++;
            $display("FAIL async_reset: req=%0b addr=%h valid=%0b instr=%h pc=%h fault=%0b, required all zero",
                     imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault);
        end
        imem_rvalid = 1'b0;
        restart_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        h0 = n_hs; k = 0;
        while (n_hs == h0 && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if ({n_hs > h0, last_hs_pc} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL restart: first pc after reset=%h, required 00000000", last_hs_pc);
        end
    endtask

    task automatic test_random();
        int h0;
        h0 = n_hs;
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) begin
                gnt_pct = int'($urandom_range(100, 30));
                rdy_pct = int'($urandom_range(100, 30));
                lat_min = int'($urandom_range(3, 1));
                lat_max = lat_min + int'($urandom_range(3, 0));
            end
            if ($urandom_range(99) < 3) do_redirect($urandom);
            else step();
        end
        n_cmp++;
        if (n_hs - h0 < 50) begin
            n_err++;
            $display("FAIL random_progress: %0d words delivered in 400 cycles, required at least 50", n_hs - h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_gnt_stall();
        test_fault();
        test_wrap_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
